spi_snoop_bridge: RTL and testbench

//  Oversampled SPI slave that gives an external host access to CPU program/data memory through the snoop port.

---
 rtl/spi_snoop_bridge.sv | 133 +++++++++++++
 tb/tb_spi_snoop_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_snoop_bridge.sv
// Oversampled mode-0 SPI slave that drives the snoop port: set-address, program-write,
// memory-read and memory-write frames, back-to-back inside one select, truncation counted.
module spi_snoop_bridge #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int ERR_W    = 8,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_ssel,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] snoopa,
    output logic [DATA_W-1:0] snoopd,
    input  logic [DATA_W-1:0] snoopq,
    output logic              snoopp,
    output logic              snoopm,
    output logic              busy,
    output logic [ERR_W-1:0]  frame_err_count
);

    localparam int F     = 2 + DATA_W;
    localparam int CTR_W = $clog2(F);

    typedef enum logic [1:0] {
        OP_ADDR   = 2'b00,
        OP_PWRITE = 2'b01,
        OP_READ   = 2'b10,
        OP_MWRITE = 2'b11
    } op_e;

    // Select is synchronised inverted so the all-zero reset state means "deselected".
    logic sck_s1, sck_s2, sck_h;
    logic sel_s1, sel_s2, sel_h;
    logic mosi_s1, mosi_s2;

    logic [CTR_W-1:0]  bit_ctr;
    logic [F-2:0]      rx_shift;
    logic [DATA_W-1:0] rd_shift;
    logic              inc_pend;

    logic              sck_rise, ss_rise, sck_edge, last_bit;
    logic [F-1:0]      frame_word;
    op_e               op;
    logic [DATA_W-1:0] payload;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {sck_s1, sck_s2, sck_h}   <= '0;
            {sel_s1, sel_s2, sel_h}   <= '0;
            {mosi_s1, mosi_s2}        <= '0;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the previous stage's old value.
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_h   <= sck_s2;
            sel_s1  <= ~spi_ssel;
            sel_s2  <= sel_s1;
            sel_h   <= sel_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    always_comb begin
        // NOTE: every output of this block is assigned up front so no latch can be inferred.
        sck_rise   = sck_s2 & ~sck_h;
        ss_rise    = ~sel_s2 & sel_h;
        sck_edge   = sck_rise & sel_s2;   // deselect wins over a coincident SCK edge
        last_bit   = (bit_ctr == CTR_W'(F - 1));
        frame_word = {rx_shift, mosi_s2};
        op         = op_e'(frame_word[F-1 -: 2]);
        payload    = frame_word[DATA_W-1:0];
    end

    assign busy = sel_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_ctr         <= '0;
            rx_shift        <= '0;
            rd_shift        <= '0;
            spi_miso        <= 1'b0;
            snoopa          <= '0;
            snoopd          <= '0;
            snoopp          <= 1'b0;
            snoopm          <= 1'b0;
            inc_pend        <= 1'b0;
            frame_err_count <= '0;
        end else begin
            snoopp   <= 1'b0;
            snoopm   <= 1'b0;
            inc_pend <= 1'b0;

            if (!sel_s2)
                bit_ctr <= '0;
            else if (sck_edge)
                bit_ctr <= last_bit ? '0 : bit_ctr + CTR_W'(1);

            if (sck_edge) begin
                rx_shift <= frame_word[F-2:0];
                if (bit_ctr == '0) begin
                    spi_miso <= 1'b0;
                    rd_shift <= snoopq;
                end else begin
                    spi_miso <= rd_shift[DATA_W-1];
                    rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
                end
            end

            // Increment lands one cycle after the strobe so the strobe sees the old address.
            if (inc_pend)
                snoopa <= snoopa + ADDR_W'(1);

            if (sck_edge && last_bit) begin
                snoopd   <= payload;
                inc_pend <= (AUTO_INC != 0) && (op != OP_ADDR);
                case (op)
                    OP_ADDR:   snoopa <= payload[ADDR_W-1:0];
                    OP_PWRITE: snoopp <= 1'b1;
                    OP_MWRITE: snoopm <= 1'b1;
                    default:   ;
                endcase
            end

            if (ss_rise && (bit_ctr != '0) && (frame_err_count != '1))
                frame_err_count <= frame_err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_spi_snoop_bridge.sv
// Directed bench for spi_snoop_bridge: an 8-bit auto-incrementing instance driven from a
// frame table, plus a 12/16-bit non-incrementing instance and truncation/reset sequences.
module tb_spi_snoop_bridge;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic ssel8 = 1'b1;
    logic ssel16 = 1'b1;

    logic        miso8, p8, m8, busy8;
    logic [7:0]  a8, d8, q8, q8_d1, err8;
    logic        miso16, p16, m16, busy16;
    logic [11:0] a16;
    logic [15:0] d16, q16, q16_d1;
    logic [7:0]  err16;

    int n_vec = 0;
    int n_err = 0;

    int p8_cnt = 0, m8_cnt = 0, m16_cnt = 0, p16_cnt = 0;
    logic [7:0]  p8_addr, m8_addr, m8_data;
    logic [11:0] m16_addr;
    logic [15:0] m16_data;

    always #5 clk = ~clk;

    spi_snoop_bridge dut8 (
        .clk(clk), .reset(reset), .spi_sck(sck), .spi_ssel(ssel8), .spi_mosi(mosi),
        .spi_miso(miso8), .snoopa(a8), .snoopd(d8), .snoopq(q8), .snoopp(p8),
        .snoopm(m8), .busy(busy8), .frame_err_count(err8)
    );

    spi_snoop_bridge #(.ADDR_W(12), .DATA_W(16), .ERR_W(8), .AUTO_INC(0)) dut16 (
        .clk(clk), .reset(reset), .spi_sck(sck), .spi_ssel(ssel16), .spi_mosi(mosi),
        .spi_miso(miso16), .snoopa(a16), .snoopd(d16), .snoopq(q16), .snoopp(p16),
        .snoopm(m16), .busy(busy16), .frame_err_count(err16)
    );

    // Memory model: read data is the inverted address, two clocks after the address.
    always @(posedge clk) begin
        q8_d1  <= ~a8;
        q8     <= q8_d1;
        q16_d1 <= ~{4'h0, a16};
        q16    <= q16_d1;
    end

    always @(negedge clk) begin
        if (p8)  begin p8_cnt++;  p8_addr = a8; end
        if (m8)  begin m8_cnt++;  m8_addr = a8; m8_data = d8; end
        if (p16) p16_cnt++;
        if (m16) begin m16_cnt++; m16_addr = a16; m16_data = d16; end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sel_lo(input bit wide);
        if (wide) ssel16 = 1'b0; else ssel8 = 1'b0;
        wait_clk(6);
    endtask

    task automatic sel_hi(input bit wide);
        wait_clk(2);
        if (wide) ssel16 = 1'b1; else ssel8 = 1'b1;
        wait_clk(6);
    endtask

    // Shifts n bits MSB first; rx holds MISO as the host sees it at each rising edge.
    task automatic spi_xfer(input bit wide, input logic [17:0] bits, input int n,
                            output logic [17:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            wait_clk(5);
            rx = {rx[16:0], wide ? miso16 : miso8};
            sck = 1'b1;
            wait_clk(5);
            sck = 1'b0;
        end
        wait_clk(6);
    endtask

    typedef struct {
        bit         new_sel;
        bit         end_sel;
        logic [1:0] op;
        logic [7:0] pay;
        logic [7:0] exp_rx;
        logic [7:0] exp_a;
        logic [7:0] exp_d;
        int         exp_p;
        int         exp_m;
        logic [7:0] exp_sa;
    } vec_t;

    vec_t tv[8];
    logic [17:0] rx;
    int p_base, m_base;

    initial begin
        //          new end op     pay    rx     a      d      p  m  strobe addr
        tv[0] = '{1, 0, 2'b00, 8'h40, 8'hFF, 8'h40, 8'h40, 0, 0, 8'h00};
        tv[1] = '{0, 1, 2'b11, 8'hA5, 8'hBF, 8'h41, 8'hA5, 0, 1, 8'h40};
        tv[2] = '{1, 0, 2'b00, 8'h10, 8'hBE, 8'h10, 8'h10, 0, 1, 8'h00};
        tv[3] = '{0, 0, 2'b10, 8'h00, 8'hEF, 8'h11, 8'h00, 0, 1, 8'h00};
        tv[4] = '{0, 0, 2'b10, 8'h00, 8'hEE, 8'h12, 8'h00, 0, 1, 8'h00};
        tv[5] = '{0, 1, 2'b10, 8'h00, 8'hED, 8'h13, 8'h00, 0, 1, 8'h00};
        tv[6] = '{1, 0, 2'b00, 8'hFF, 8'hEC, 8'hFF, 8'hFF, 0, 1, 8'h00};
        tv[7] = '{0, 1, 2'b01, 8'h3C, 8'h00, 8'h00, 8'h3C, 1, 1, 8'hFF};

        wait_clk(4);
        reset = 1'b0;
        wait_clk(4);
        check("reset snoopa", 32'(a8), 32'h0);
        check("reset snoopd", 32'(d8), 32'h0);
        check("reset miso", 32'(miso8), 32'h0);
        check("reset busy", 32'(busy8), 32'h0);
        check("reset errcnt", 32'(err8), 32'h0);

        foreach (tv[i]) begin
            if (tv[i].new_sel) begin
                sel_lo(1'b0);
                check($sformatf("v%0d busy", i), 32'(busy8), 32'h1);
            end
            spi_xfer(1'b0, {8'h00, tv[i].op, tv[i].pay}, 10, rx);
            check($sformatf("v%0d miso payload", i), 32'(rx[7:0]), 32'(tv[i].exp_rx));
            check($sformatf("v%0d snoopa", i), 32'(a8), 32'(tv[i].exp_a));
            check($sformatf("v%0d snoopd", i), 32'(d8), 32'(tv[i].exp_d));
            check($sformatf("v%0d snoopp count", i), 32'(p8_cnt), 32'(tv[i].exp_p));
            check($sformatf("v%0d snoopm count", i), 32'(m8_cnt), 32'(tv[i].exp_m));
            if (tv[i].op == 2'b01)
                check($sformatf("v%0d snoopp addr", i), 32'(p8_addr), 32'(tv[i].exp_sa));
            if (tv[i].op == 2'b11) begin
                check($sformatf("v%0d snoopm addr", i), 32'(m8_addr), 32'(tv[i].exp_sa));
                check($sformatf("v%0d snoopm data", i), 32'(m8_data), 32'(tv[i].pay));
            end
            if (tv[i].end_sel) sel_hi(1'b0);
        end
        check("clean deselect errcnt", 32'(err8), 32'h0);
        check("idle busy", 32'(busy8), 32'h0);

        // Truncated frame: 5 bits of a memory write, then deselect.
        sel_lo(1'b0);
        spi_xfer(1'b0, 18'h0001F, 5, rx);
        sel_hi(1'b0);
        check("trunc errcnt", 32'(err8), 32'h1);
        check("trunc snoopa", 32'(a8), 32'h00);
        check("trunc snoopd", 32'(d8), 32'h3C);
        check("trunc snoopm count", 32'(m8_cnt), 32'h1);
        check("trunc snoopp count", 32'(p8_cnt), 32'h1);

        for (int k = 0; k < 254; k++) begin
            sel_lo(1'b0);
            spi_xfer(1'b0, 18'h00001, 1, rx);
            sel_hi(1'b0);
        end
        check("errcnt at 255", 32'(err8), 32'hFF);
        sel_lo(1'b0);
        spi_xfer(1'b0, 18'h00001, 1, rx);
        sel_hi(1'b0);
        check("errcnt saturated", 32'(err8), 32'hFF);

        // Reset asserted seven bits into a memory-write frame.
        sel_lo(1'b0);
        spi_xfer(1'b0, 18'h00077, 10, rx);
        check("pre-reset snoopa", 32'(a8), 32'h77);
        p_base = p8_cnt;
        m_base = m8_cnt;
        spi_xfer(1'b0, 18'h0037F, 7, rx);
        #3 reset = 1'b1;
        #1;
        check("async reset snoopa", 32'(a8), 32'h0);
        check("async reset snoopd", 32'(d8), 32'h0);
        check("async reset busy", 32'(busy8), 32'h0);
        check("async reset errcnt", 32'(err8), 32'h0);
        check("async reset miso", 32'(miso8), 32'h0);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(4);
        sel_hi(1'b0);
        check("post-reset errcnt", 32'(err8), 32'h0);
        sel_lo(1'b0);
        spi_xfer(1'b0, 18'h0005A, 10, rx);
        sel_hi(1'b0);
        check("post-reset frame snoopa", 32'(a8), 32'h5A);
        check("post-reset frame snoopd", 32'(d8), 32'h5A);
        check("reset no strobe p", 32'(p8_cnt), 32'(p_base));
        check("reset no strobe m", 32'(m8_cnt), 32'(m_base));

        // Wide instance without auto-increment.
        sel_lo(1'b1);
        spi_xfer(1'b1, {2'b00, 16'h0ABC}, 18, rx);
        check("w16 snoopa after addr", 32'(a16), 32'hABC);
        spi_xfer(1'b1, {2'b11, 16'h1234}, 18, rx);
        check("w16 miso payload", 32'(rx[15:0]), 32'hF543);
        check("w16 snoopm count", 32'(m16_cnt), 32'h1);
        check("w16 snoopm addr", 32'(m16_addr), 32'hABC);
        check("w16 snoopm data", 32'(m16_data), 32'h1234);
        check("w16 snoopa held", 32'(a16), 32'hABC);
        check("w16 snoopd", 32'(d16), 32'h1234);
        check("w16 snoopp count", 32'(p16_cnt), 32'h0);
        sel_hi(1'b1);
        check("w16 errcnt", 32'(err16), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
